// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with per-frame zero-tail termination.
// Accepts one information bit per handshake and emits one 2-bit symbol per
// handshake; two tail symbols return the trellis to state 00 at frame end.
module conv_encoder_framer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_bit,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_sym,
   output logic        out_last,
   output logic        frame_done,
   output logic        busy,
   output logic [15:0] sym_count
);

   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} state_t;

   state_t      state_q, state_d;
   logic [1:0]  sr_q, sr_d;
   logic        out_valid_q, out_valid_d;
   logic [1:0]  out_sym_q, out_sym_d;
   logic        out_last_q, out_last_d;
   logic [15:0] sym_count_q, sym_count_d;

   logic        slot_free;
   logic        accept;
   logic        out_hs;
   logic        load;
   logic        load_last;
   logic        enc_bit;
   logic [2:0]  taps;

   // Next-state, symbol load and handshake bookkeeping
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      out_valid_d = out_valid_q & ~out_ready;
      out_sym_d   = out_sym_q;
      out_last_d  = out_last_q;
      sym_count_d = sym_count_q;
      load        = 1'b0;
      load_last   = 1'b0;
      enc_bit     = 1'b0;

      slot_free = ~out_valid_q | out_ready;
      out_hs    = out_valid_q & out_ready;
      in_ready  = rst & slot_free & ((state_q == IDLE) | (state_q == DATA));
      accept    = in_valid & in_ready;

      case (state_q)
         IDLE, DATA: begin
            if (accept) begin
               load    = 1'b1;
               enc_bit = in_bit;
               state_d = in_last ? TAIL1 : DATA;
            end
         end
         TAIL1: begin
            if (slot_free) begin
               load    = 1'b1;
               state_d = TAIL2;
            end
         end
         TAIL2: begin
            if (slot_free) begin
               load      = 1'b1;
               load_last = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      taps = {enc_bit, sr_q};
      if (load) begin
         out_sym_d   = {^(G0 & taps), ^(G1 & taps)};
         out_valid_d = 1'b1;
         out_last_d  = load_last;
         sr_d        = load_last ? 2'b00 : {enc_bit, sr_q[1]};
      end

      if (out_hs) begin
         if (out_last_q)
            sym_count_d = '0;
         else if (sym_count_q != 16'hFFFF)
            sym_count_d = sym_count_q + 16'd1;
      end
   end

   // State and output register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         out_valid_q <= 1'b0;
         out_sym_q   <= '0;
         out_last_q  <= 1'b0;
         sym_count_q <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         out_valid_q <= out_valid_d;
         out_sym_q   <= out_sym_d;
         out_last_q  <= out_last_d;
         sym_count_q <= sym_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_sym    = out_sym_q;
   assign out_last   = out_last_q;
   assign sym_count  = sym_count_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = rst & out_hs & out_last_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer: expected symbols are queued when a
// frame is started and compared whenever an output handshake occurs.
module tb_conv_encoder_framer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_bit = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_sym;
   logic        out_last;
   logic        frame_done;
   logic        busy;
   logic [15:0] sym_count;

   conv_encoder_framer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bit     (in_bit),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sym    (out_sym),
      .out_last   (out_last),
      .frame_done (frame_done),
      .busy       (busy),
      .sym_count  (sym_count)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [2:0] exp_q[$];          // {last, sym}
   int         hs_count = 0;
   int         fr_cnt   = 0;
   int         cyc      = 0;
   int         prev_cyc = 0;
   bit         have_prev = 1'b0;
   bit         gapless   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every symbol handshake
   always @(negedge clk) begin
      logic [2:0] e;
      if (!rst) begin
         fr_cnt    = 0;
         have_prev = 1'b0;
         check("frame_done_in_reset", {15'd0, frame_done}, 16'd0);
      end else if (out_valid && out_ready) begin
         check("sym_available", exp_q.size() > 0 ? 16'd1 : 16'd0, 16'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_sym", {14'd0, out_sym}, {14'd0, e[1:0]});
            check("out_last", {15'd0, out_last}, {15'd0, e[2]});
            check("frame_done", {15'd0, frame_done}, {15'd0, e[2]});
            check("sym_count", sym_count, fr_cnt[15:0]);
            if (gapless && have_prev)
               check("gapless", 16'(cyc - prev_cyc), 16'd1);
            prev_cyc  = cyc;
            have_prev = 1'b1;
            fr_cnt    = e[2] ? 0 : fr_cnt + 1;
         end
         hs_count++;
      end else begin
         check("frame_done_idle", {15'd0, frame_done}, 16'd0);
      end
   end

   task automatic push(input logic last, input logic [1:0] sym);
      exp_q.push_back({last, sym});
   endtask

   task automatic push_frame1();
      push(1'b0, 2'b11); push(1'b0, 2'b10); push(1'b0, 2'b00);
      push(1'b0, 2'b01); push(1'b0, 2'b01); push(1'b1, 2'b11);
   endtask

   // Present one bit and hold it until accepted; returns 1 time unit after the accepting edge
   task automatic send_bit(input logic b, input logic last);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_bit   = b;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", {15'd0, in_ready}, 16'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame1();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain", 16'(exp_q.size()), 16'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int t;

      // Reset state
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst_out_sym", {14'd0, out_sym}, 16'd0);
      check("rst_out_last", {15'd0, out_last}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_sym_count", sym_count, 16'd0);
      check("rst_in_ready", {15'd0, in_ready}, 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("release_in_ready", {15'd0, in_ready}, 16'd1);
      @(posedge clk);
      #1;

      // Frame 1,0,1,1 with continuous out_ready
      push_frame1();
      send_frame1();
      drain();
      check("s1_busy_end", {15'd0, busy}, 16'd0);

      // Single-bit frame
      push(1'b0, 2'b11); push(1'b0, 2'b10); push(1'b1, 2'b11);
      send_bit(1'b1, 1'b1);
      check("s2_busy_tail", {15'd0, busy}, 16'd1);
      drain();
      check("s2_busy_end", {15'd0, busy}, 16'd0);

      // Backpressure while the second symbol is presented
      push_frame1();
      base = hs_count;
      fork
         send_frame1();
         begin
            t = 0;
            while (hs_count < base + 1 && t < 50) begin
               @(posedge clk);
               t++;
            end
            #1;
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_out_sym", {14'd0, out_sym}, 16'd2);
               check("stall_out_valid", {15'd0, out_valid}, 16'd1);
               check("stall_in_ready", {15'd0, in_ready}, 16'd0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset while in TAIL1, then rerun frame 1
      push_frame1();
      send_frame1();
      check("tail1_busy", {15'd0, busy}, 16'd1);
      check("tail1_in_ready", {15'd0, in_ready}, 16'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", {15'd0, in_ready}, 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
      check("midrst_sym_count", sym_count, 16'd0);
      check("midrst_busy", {15'd0, busy}, 16'd0);
      @(posedge clk);
      #1;
      push_frame1();
      send_frame1();
      drain();

      // Back-to-back frames with in_valid held through the tail
      gapless   = 1'b1;
      have_prev = 1'b0;
      push(1'b0, 2'b11); push(1'b0, 2'b10); push(1'b1, 2'b11);
      push(1'b0, 2'b00); push(1'b0, 2'b00); push(1'b1, 2'b00);
      send_bit(1'b1, 1'b1);
      in_valid = 1'b1;
      in_bit   = 1'b0;
      in_last  = 1'b1;
      check("b2b_tail_in_ready", {15'd0, in_ready}, 16'd0);
      send_bit(1'b0, 1'b1);
      drain();
      gapless = 1'b0;
      check("b2b_busy_end", {15'd0, busy}, 16'd0);
      check("b2b_sym_count_end", sym_count, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
